// File: rtl/osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : osc_freq_meter
// Brief    : Gated rising-edge counter that measures an asynchronous oscillator
//            against clk and flags results outside [LO_LIMIT, HI_LIMIT].
// Revision : 1.0 - initial release
// ============================================================================
module osc_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned WARM_CYCLES = 64,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LO_LIMIT    = 100,
    parameter int unsigned HI_LIMIT    = 400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             oscout,
    output logic             oscen,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             meas_valid,
    output logic             osc_fail
);

    localparam int unsigned WARM_W = $clog2(WARM_CYCLES + 1);
    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);

    localparam logic [WARM_W-1:0] c_warm_last = WARM_W'(WARM_CYCLES - 1);
    localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [WARM_W-1:0]   warm_cnt_q,   warm_cnt_d;
    logic [GATE_W-1:0]   gate_cnt_q,   gate_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q,   edge_cnt_d;
    logic [CNT_W-1:0]    count_q,      count_d;
    logic                meas_valid_q, meas_valid_d;
    logic                osc_fail_q,   osc_fail_d;
    logic                sync1_q,      sync1_d;
    logic                sync2_q,      sync2_d;
    logic                sync3_q,      sync3_d;

    logic                w_edge;
    logic [CNT_W-1:0]    w_edge_next;

    // Two flops resolve metastability; the third gives the previous level.
    assign sync1_d = oscout;
    assign sync2_d = sync1_q;
    assign sync3_d = sync2_q;
    assign w_edge  = sync2_q & ~sync3_q;

    // Saturating increment so an over-range input reads as full scale.
    assign w_edge_next = (w_edge && (edge_cnt_q != c_cnt_max))
                       ? edge_cnt_q + CNT_W'(1)
                       : edge_cnt_q;

    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        count_d      = count_q;
        meas_valid_d = 1'b0;
        osc_fail_d   = osc_fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WARMUP;
                    warm_cnt_d = '0;
                end
            end

            S_WARMUP: begin
                if (warm_cnt_q == c_warm_last) begin
                    state_d    = S_MEASURE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end

            S_MEASURE: begin
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                edge_cnt_d = w_edge_next;
                // Result is published on entry to DONE so it is stable while
                // meas_valid is high; the final-cycle edge is included.
                if (gate_cnt_q == c_gate_last) begin
                    state_d      = S_DONE;
                    count_d      = w_edge_next;
                    meas_valid_d = 1'b1;
                    osc_fail_d   = (32'(w_edge_next) < LO_LIMIT) ||
                                   (32'(w_edge_next) > HI_LIMIT);
                end
            end

            S_DONE: begin
                if (cont) begin
                    state_d    = S_MEASURE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            warm_cnt_q   <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            count_q      <= '0;
            meas_valid_q <= 1'b0;
            osc_fail_q   <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            count_q      <= count_d;
            meas_valid_q <= meas_valid_d;
            osc_fail_q   <= osc_fail_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign oscen      = (state_q != S_IDLE);
    assign count      = count_q;
    assign meas_valid = meas_valid_q;
    assign osc_fail   = osc_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_freq_meter
// Brief    : Directed, table-driven self-checking bench for osc_freq_meter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_freq_meter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cont;
    logic        oscout;
    logic        oscen;
    logic        busy;
    logic [15:0] count;
    logic        meas_valid;
    logic        osc_fail;

    logic        start2;
    logic        cont2;
    logic        oscout2;
    logic        oscen2;
    logic        busy2;
    logic [3:0]  count2;
    logic        meas_valid2;
    logic        osc_fail2;

    int osc_period;
    int checks;
    int errors;

    osc_freq_meter #(
        .GATE_CYCLES(1000), .WARM_CYCLES(64), .CNT_W(16),
        .LO_LIMIT(100), .HI_LIMIT(400)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .oscout(oscout),
        .oscen(oscen), .busy(busy), .count(count),
        .meas_valid(meas_valid), .osc_fail(osc_fail)
    );

    osc_freq_meter #(
        .GATE_CYCLES(100), .WARM_CYCLES(4), .CNT_W(4),
        .LO_LIMIT(2), .HI_LIMIT(10)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .start(start2), .cont(cont2), .oscout(oscout2),
        .oscen(oscen2), .busy(busy2), .count(count2),
        .meas_valid(meas_valid2), .osc_fail(osc_fail2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main oscillator: period osc_period clk cycles, 0 means stopped low.
    initial begin
        int phase;
        phase  = 0;
        oscout = 1'b0;
        forever begin
            @(negedge clk);
            if (osc_period == 0) begin
                phase  = 0;
                oscout = 1'b0;
            end else begin
                phase  = (phase + 1 >= osc_period) ? 0 : phase + 1;
                oscout = (phase < osc_period / 2);
            end
        end
    end

    // Saturation oscillator: fixed period of 4 clk cycles.
    initial begin
        int phase2;
        phase2  = 0;
        oscout2 = 1'b0;
        forever begin
            @(negedge clk);
            phase2  = (phase2 + 1) % 4;
            oscout2 = (phase2 < 2);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns once the main DUT is back in IDLE.
    task automatic measure_once(output int oscen_cyc, output int mv_cnt,
                                output int cnt_seen, output int fail_seen,
                                output int timed_out);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        oscen_cyc = 0;
        mv_cnt    = 0;
        cnt_seen  = -1;
        fail_seen = -1;
        timed_out = 1;
        for (int i = 0; i < 1300; i++) begin
            if (oscen) oscen_cyc++;
            if (meas_valid) begin
                mv_cnt++;
                cnt_seen  = int'(count);
                fail_seen = int'(osc_fail);
            end
            if (!busy) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int period;
        int exp_count;
        int exp_fail;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int oc, mv, cs, fs, to;
        checks     = 0;
        errors     = 0;
        osc_period = 8;
        rst        = 1'b1;
        start      = 1'b0;
        cont       = 1'b0;
        start2     = 1'b0;
        cont2      = 1'b0;

        vecs[0] = '{period: 8,  exp_count: 125, exp_fail: 0};
        vecs[1] = '{period: 10, exp_count: 100, exp_fail: 0};
        vecs[2] = '{period: 4,  exp_count: 250, exp_fail: 0};
        vecs[3] = '{period: 5,  exp_count: 200, exp_fail: 0};
        vecs[4] = '{period: 20, exp_count: 50,  exp_fail: 1};
        vecs[5] = '{period: 0,  exp_count: 0,   exp_fail: 1};

        repeat (3) @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_oscen", int'(oscen), 0);
        check("rst_count", int'(count), 0);
        check("rst_valid", int'(meas_valid), 0);
        check("rst_fail",  int'(osc_fail), 0);
        check("rst_count_sat", int'(count2), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of the first window discards it silently.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (563) @(negedge clk);
        check("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",  int'(busy), 0);
        check("midrst_oscen", int'(oscen), 0);
        check("midrst_count", int'(count), 0);
        mv = 0;
        for (int i = 0; i < 1200; i++) begin
            if (meas_valid) mv++;
            @(negedge clk);
        end
        check("midrst_no_valid", mv, 0);
        check("midrst_count_after", int'(count), 0);

        for (int v = 0; v < 6; v++) begin
            osc_period = vecs[v].period;
            repeat (20) @(negedge clk);
            measure_once(oc, mv, cs, fs, to);
            check($sformatf("vec%0d_timeout", v), to, 0);
            check($sformatf("vec%0d_oscen_cycles", v), oc, 1065);
            check($sformatf("vec%0d_valid_pulses", v), mv, 1);
            check($sformatf("vec%0d_count", v), cs, vecs[v].exp_count);
            check($sformatf("vec%0d_fail", v), fs, vecs[v].exp_fail);
        end

        // Continuous mode: three back-to-back windows, then cont drops mid-window.
        begin
            int t_last, n_mv, oscen_cyc, dropped, done;
            osc_period = 10;
            repeat (20) @(negedge clk);
            cont  = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start     = 1'b0;
            t_last    = -1;
            n_mv      = 0;
            oscen_cyc = 0;
            dropped   = 0;
            done      = 0;
            for (int i = 0; i < 4500; i++) begin
                if (!busy) begin
                    done = 1;
                    break;
                end
                if (oscen) oscen_cyc++;
                else dropped++;
                if (meas_valid) begin
                    n_mv++;
                    check("cont_count", int'(count), 100);
                    check("cont_fail", int'(osc_fail), 0);
                    if (t_last >= 0) check("cont_interval", i - t_last, 1001);
                    t_last = i;
                end
                if (n_mv == 3 && i == t_last + 300) cont = 1'b0;
                @(negedge clk);
            end
            check("cont_finished", done, 1);
            check("cont_pulses", n_mv, 4);
            check("cont_oscen_drop", dropped, 0);
            check("cont_oscen_cycles", oscen_cyc, 1065 + 3 * 1001);
        end

        // start pulses while busy, including during the result cycle.
        begin
            int n_mv, last_cnt;
            osc_period = 8;
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            n_mv     = 0;
            last_cnt = -1;
            for (int i = 0; i < 1300; i++) begin
                start = 1'b0;
                if (!busy) break;
                if (meas_valid) begin
                    n_mv++;
                    last_cnt = int'(count);
                end
                if (i == 10 || i == 600 || meas_valid) start = 1'b1;
                @(negedge clk);
            end
            start = 1'b0;
            for (int i = 0; i < 1200; i++) begin
                if (meas_valid) n_mv++;
                @(negedge clk);
            end
            check("busy_start_pulses", n_mv, 1);
            check("busy_start_count", last_cnt, 125);
            check("busy_start_idle", int'(busy), 0);
        end

        // Saturating counter on the narrow instance.
        begin
            int n_mv, cs2, fs2;
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            n_mv   = 0;
            cs2    = -1;
            fs2    = -1;
            for (int i = 0; i < 200; i++) begin
                if (meas_valid2) begin
                    n_mv++;
                    cs2 = int'(count2);
                    fs2 = int'(osc_fail2);
                end
                @(negedge clk);
            end
            check("sat_pulses", n_mv, 1);
            check("sat_count", cs2, 15);
            check("sat_fail", fs2, 1);
            check("sat_idle", int'(busy2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/osc_freq_meter.md
OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 1000, clk cycles per measurement window (>=2).
REQ-002 Parameter WARM_CYCLES, default 64, clk cycles the oscillator runs after enable before counting starts (>=1).
REQ-003 Parameter CNT_W, default 16, width of the edge count result.
REQ-004 Parameter LO_LIMIT, default 100, minimum acceptable edge count per window.
REQ-005 Parameter HI_LIMIT, default 400, maximum acceptable edge count per window.
REQ-006 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port start, input, 1, one-cycle request to begin one measurement.
REQ-009 Port cont, input, 1, continuous mode; when high, a new window starts immediately after each result.
REQ-010 Port oscout, input, 1, asynchronous oscillator output under test.
REQ-011 Port oscen, output, 1, oscillator enable.
REQ-012 Port busy, output, 1, high whenever state is not IDLE.
REQ-013 Port count, output, CNT_W, rising-edge count of the last completed window.
REQ-014 Port meas_valid, output, 1, one-cycle pulse when count updates.
REQ-015 Port osc_fail, output, 1, result of last window outside [LO_LIMIT, HI_LIMIT].

Function
REQ-016 oscout passes through a 2-flop synchronizer and a third flop for edge detection; a rising edge is sync2=1 and sync3=0.
REQ-017 The block counts only edges whose synchronized frequency is below clk/2; faster inputs alias, and measuring them is not supported.
REQ-018 FSM states: IDLE, WARMUP, MEASURE, DONE.
REQ-019 IDLE: oscen=0; start=1 -> WARMUP, warm counter cleared.
REQ-020 WARMUP: oscen=1; after exactly WARM_CYCLES cycles -> MEASURE, edge counter and gate counter cleared.
REQ-021 MEASURE: oscen=1; the edge counter increments on each detected rising edge; the gate counter increments every cycle; MEASURE lasts exactly GATE_CYCLES cycles.
REQ-022 The edge counter saturates at 2^CNT_W-1 and does not wrap.
REQ-023 On the last MEASURE cycle, an edge detected in that cycle is included in the count.
REQ-024 DONE lasts one cycle: count loads, meas_valid=1, and osc_fail is updated to (count<LO_LIMIT or count>HI_LIMIT).
REQ-025 DONE -> MEASURE with counters cleared if cont=1; oscen stays 1 and no warm-up repeats.
REQ-026 DONE -> IDLE if cont=0.
REQ-027 start is ignored while busy=1.
REQ-028 If cont is deasserted mid-window, the current window completes and reports, then the FSM goes to IDLE.
REQ-029 If the oscillator is stopped, the count is 0 and osc_fail=1 (when LO_LIMIT>0).
REQ-030 start and cont are sampled only in the states named above; start and cont high together in IDLE behave as start.

Reset
REQ-031 rst=1 forces IDLE, oscen=0, busy=0, count=0, meas_valid=0, osc_fail=0, and clears all counters and synchronizer flops on the next clk edge.
REQ-032 rst takes priority over every other input; reset mid-window discards the partial count with no meas_valid pulse.

Verification
REQ-033 GATE_CYCLES=1000, WARM_CYCLES=64, oscout toggling every 4 clk, one start -> oscen high for 1065 cycles, one meas_valid with count=125, osc_fail=0, then IDLE.
REQ-034 oscout held at 0, start -> count=0, osc_fail=1, meas_valid pulses once.
REQ-035 cont=1 with oscout period 10 clk -> back-to-back meas_valid every 1001 cycles, each count=100, oscen never drops, and no second warm-up occurs.
REQ-036 CNT_W=4, oscout period 4 clk -> count saturates at 15 and osc_fail=1.
REQ-037 rst asserted at cycle 500 of MEASURE -> next cycle IDLE, oscen=0, count unchanged=0, and no meas_valid.
REQ-038 start pulses while busy -> ignored; exactly one meas_valid per accepted start.
